// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   EX-stage operand forwarding and decode-stage load-use hazard handling for
//   the 5-stage pipeline. Each load-use hazard produces exactly LOAD_LAT
//   bubbles. A saturating counter records how many cycles decode was stalled.
//
// Ports
//   clk, reset            pipeline clock; synchronous active-high reset
//   src_d, use_d          decode source registers and their read enables
//   src_e                 execute source registers (forwarding targets)
//   regwrite_e/memtoreg_e/writereg_e   execute-stage writer (load detection)
//   regwrite_m/writereg_m memory-stage writer (forward source 01)
//   regwrite_w/writereg_w writeback-stage writer (forward source 10)
//   flush_in              redirect; cancels any stall in progress
//   fwd_sel               per-operand mux select, operand i at [2i +: 2]
//   stall_f, stall_d      hold PC and IF/ID register
//   flush_e               inject a bubble into ID/EX
//   stall_cycles          saturating count of cycles with stall_d high
//
// FSM states
//   state | meaning
//   IDLE  | no stall pending; a new hazard stalls combinationally this cycle
//   WAIT  | remaining bubbles of a LOAD_LAT>1 hazard; cnt bubbles still owed
module hazard_forward_unit #(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*ADDR_W-1:0] src_d,
  input  logic [NUM_SRC-1:0]        use_d,
  input  logic [NUM_SRC*ADDR_W-1:0] src_e,
  input  logic                      regwrite_e,
  input  logic                      memtoreg_e,
  input  logic [ADDR_W-1:0]         writereg_e,
  input  logic                      regwrite_m,
  input  logic [ADDR_W-1:0]         writereg_m,
  input  logic                      regwrite_w,
  input  logic [ADDR_W-1:0]         writereg_w,
  input  logic                      flush_in,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_e,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          haz;
  logic          haz_any;
  logic          stall;

  // Forwarding: M has priority over W; register 0 is never forwarded.
  always_comb begin
    fwd_sel = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (regwrite_m && (writereg_m != '0) &&
            (writereg_m == src_e[i*ADDR_W +: ADDR_W]))
          fwd_sel[2*i +: 2] = 2'b01;
        else if (regwrite_w && (writereg_w != '0) &&
                 (writereg_w == src_e[i*ADDR_W +: ADDR_W]))
          fwd_sel[2*i +: 2] = 2'b10;
      end
    end
  end

  always_comb begin
    haz_any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (use_d[i] && (src_d[i*ADDR_W +: ADDR_W] == writereg_e))
        haz_any = 1'b1;
    end
    haz = regwrite_e && memtoreg_e && (writereg_e != '0) && haz_any;
  end

  // The first bubble comes straight from IDLE; WAIT only supplies the rest,
  // so LOAD_LAT=1 never leaves IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (haz && !flush_in) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (flush_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE)
            state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      stall   = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS*AW-1:0] src_d, src_e;
  logic [NS-1:0] use_d;
  logic          regwrite_e, memtoreg_e, regwrite_m, regwrite_w, flush_in;
  logic [AW-1:0] writereg_e, writereg_m, writereg_w;

  logic [3:0]  fwd0, fwd1, fwd2;
  logic [2:0]  sf, sd, fe;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  always #5 clk = ~clk;

  hazard_forward_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .src_d(src_d), .use_d(use_d), .src_e(src_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .writereg_e(writereg_e),
    .regwrite_m(regwrite_m), .writereg_m(writereg_m),
    .regwrite_w(regwrite_w), .writereg_w(writereg_w), .flush_in(flush_in),
    .fwd_sel(fwd0), .stall_f(sf[0]), .stall_d(sd[0]), .flush_e(fe[0]),
    .stall_cycles(cnt0));

  hazard_forward_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .src_d(src_d), .use_d(use_d), .src_e(src_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .writereg_e(writereg_e),
    .regwrite_m(regwrite_m), .writereg_m(writereg_m),
    .regwrite_w(regwrite_w), .writereg_w(writereg_w), .flush_in(flush_in),
    .fwd_sel(fwd1), .stall_f(sf[1]), .stall_d(sd[1]), .flush_e(fe[1]),
    .stall_cycles(cnt1));

  hazard_forward_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .src_d(src_d), .use_d(use_d), .src_e(src_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .writereg_e(writereg_e),
    .regwrite_m(regwrite_m), .writereg_m(writereg_m),
    .regwrite_w(regwrite_w), .writereg_w(writereg_w), .flush_in(flush_in),
    .fwd_sel(fwd2), .stall_f(sf[2]), .stall_d(sd[2]), .flush_e(fe[2]),
    .stall_cycles(cnt2));

  typedef struct {
    int fwd;
    int stall [3];
    int cnt   [3];
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: bubbles still owed after the current one, per instance.
  int lat  [3] = '{1, 3, 3};
  int maxc [3] = '{65535, 65535, 15};
  int owed [3] = '{0, 0, 0};
  int mcnt [3] = '{0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int reg_of(input logic [NS*AW-1:0] v, input int i);
    logic [NS*AW-1:0] t;
    t = v >> (i * AW);
    return int'(t[AW-1:0]);
  endfunction

  function automatic int model_fwd();
    int r = 0;
    for (int i = 0; i < NS; i++) begin
      int s = reg_of(src_e, i);
      int f = 0;
      if (regwrite_m && writereg_m != 0 && int'(writereg_m) == s) f = 1;
      else if (regwrite_w && writereg_w != 0 && int'(writereg_w) == s) f = 2;
      r += f << (2 * i);
    end
    return r;
  endfunction

  function automatic bit model_haz();
    bit hit = 0;
    for (int i = 0; i < NS; i++)
      if (use_d[i] && reg_of(src_d, i) == int'(writereg_e)) hit = 1;
    return regwrite_e && memtoreg_e && writereg_e != 0 && hit;
  endfunction

  // Inputs are already set; queue this cycle's expectation, then let the
  // clock edge happen and advance the model with the same inputs.
  task automatic step();
    exp_t e;
    bit   h;
    h = model_haz();
    e.fwd = reset ? 0 : model_fwd();
    for (int k = 0; k < 3; k++) begin
      if (reset)          e.stall[k] = 0;
      else if (owed[k] > 0) e.stall[k] = !flush_in;
      else                e.stall[k] = h && !flush_in;
      e.cnt[k] = mcnt[k];
    end
    q.push_back(e);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        owed[k] = 0;
        mcnt[k] = 0;
      end else begin
        if (owed[k] > 0)            owed[k] = flush_in ? 0 : owed[k] - 1;
        else if (h && !flush_in)    owed[k] = lat[k] - 1;
        mcnt[k] = mcnt[k] + e.stall[k];
        if (mcnt[k] > maxc[k]) mcnt[k] = maxc[k];
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    src_d = '0; use_d = '0; src_e = '0;
    regwrite_e = 0; memtoreg_e = 0; writereg_e = '0;
    regwrite_m = 0; writereg_m = '0; regwrite_w = 0; writereg_w = '0;
    flush_in = 0;
  endtask

  task automatic set_load_hazard(input logic [1:0] u);
    regwrite_e = 1; memtoreg_e = 1; writereg_e = 5'd5;
    src_d = {5'd0, 5'd5}; use_d = u;
  endtask

  task automatic clear_hazard();
    regwrite_e = 0; memtoreg_e = 0; writereg_e = '0; use_d = '0; src_d = '0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fwd_sel_l1", int'(fwd0), e.fwd);
      chk("fwd_sel_l3", int'(fwd1), e.fwd);
      chk("fwd_sel_sat", int'(fwd2), e.fwd);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("stall_f[%0d]", k), int'(sf[k]), e.stall[k]);
        chk($sformatf("stall_d[%0d]", k), int'(sd[k]), e.stall[k]);
        chk($sformatf("flush_e[%0d]", k), int'(fe[k]), e.stall[k]);
      end
      chk("stall_cycles_l1", int'(cnt0), e.cnt[0]);
      chk("stall_cycles_l3", int'(cnt1), e.cnt[1]);
      chk("stall_cycles_sat", int'(cnt2), e.cnt[2]);
    end
  end

  initial begin
    clear_inputs();
    reset = 1;
    // Forwarding and hazard inputs active while in reset: outputs must stay 0.
    regwrite_m = 1; writereg_m = 5'd8; regwrite_w = 1; writereg_w = 5'd8;
    src_e = {5'd0, 5'd8};
    set_load_hazard(2'b01);
    @(posedge clk); #1;
    step(); step();
    reset = 0;
    clear_hazard();
    step();                                     // M beats W on operand 0

    clear_inputs();
    regwrite_m = 1; writereg_m = 5'd0; src_e = {5'd0, 5'd3};
    step();                                     // r0 never forwarded
    regwrite_w = 1; writereg_w = 5'd9; src_e = {5'd9, 5'd3};
    step();                                     // operand 1 from W

    clear_inputs();
    set_load_hazard(2'b01); step();
    clear_hazard(); repeat (4) step();          // 1 bubble vs 3 bubbles

    set_load_hazard(2'b00); step();             // operand not used
    clear_hazard(); step();

    set_load_hazard(2'b01); step();
    clear_hazard(); flush_in = 1; step();       // flush on 2nd stall cycle
    flush_in = 0; repeat (2) step();

    set_load_hazard(2'b01); flush_in = 1; step(); // flush beats hazard
    clear_hazard(); flush_in = 0; step();

    set_load_hazard(2'b01); step();
    clear_hazard(); reset = 1; step();          // reset while in WAIT
    reset = 0; repeat (3) step();

    set_load_hazard(2'b11); repeat (20) step(); // chained hazards saturate CNT_W=4
    clear_hazard(); repeat (2) step();

    for (int n = 0; n < 400; n++) begin
      regwrite_e = 1'($urandom_range(0, 1));
      memtoreg_e = 1'($urandom_range(0, 1));
      writereg_e = 5'($urandom_range(0, 3));
      src_d      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      use_d      = 2'($urandom_range(0, 3));
      src_e      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      regwrite_m = 1'($urandom_range(0, 1));
      writereg_m = 5'($urandom_range(0, 3));
      regwrite_w = 1'($urandom_range(0, 1));
      writereg_w = 5'($urandom_range(0, 3));
      flush_in   = ($urandom_range(0, 9) == 0);
      reset      = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0;
    clear_inputs();
    step();
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
